// File: rtl/robot_sensor_conditioner_if.sv
// rtl/robot_sensor_conditioner_if.sv - sensor conditioner port bundle
// The raw_x input, the conditioned outputs and the glitch counters, with master/slave views.
interface robot_sensor_conditioner_if #(
  parameter int NCH = 5,
  parameter int CW  = 8
);
  logic [NCH-1:0]    raw_x;
  logic [NCH-1:0]    x_clean;
  logic [NCH-1:0]    x_rise;
  logic [NCH-1:0]    x_fall;
  logic              settled;
  logic [NCH*CW-1:0] glitch_cnt;

  modport master (
    output raw_x,
    input  x_clean,
    input  x_rise,
    input  x_fall,
    input  settled,
    input  glitch_cnt
  );

  modport slave (
    input  raw_x,
    output x_clean,
    output x_rise,
    output x_fall,
    output settled,
    output glitch_cnt
  );
endinterface

// File: rtl/robot_sensor_conditioner.sv
// rtl/robot_sensor_conditioner.sv - 2-flop sync + per-channel debounce, edge pulses, settled flag
// Optional per-channel glitch counters are built when GLITCH_CNT_EN is defined.
module robot_sensor_conditioner #(
  parameter int NCH        = 5,
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 8
) (
  input logic                       clk,
  input logic                       rst,
  robot_sensor_conditioner_if.slave bus
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_CHECK = 1'b1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES);
  localparam int            SW       = CW + 1;
  localparam logic [SW-1:0] START_LAST = SW'(DEB_CYCLES + 2);

  if (DEB_CYCLES < 1 || DEB_CYCLES > (2**CW) - 1) begin : g_bad_deb
    $error("robot_sensor_conditioner: DEB_CYCLES out of range 1..2**CW-1");
  end

  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [NCH-1:0]         state_q, state_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         clean_q, clean_d;
  logic [NCH-1:0]         rise_q, rise_d;
  logic [NCH-1:0]         fall_q, fall_d;
  logic [SW-1:0]          start_q, start_d;
  logic                   settled_q, settled_d;
`ifdef GLITCH_CNT_EN
  logic [NCH-1:0]         glitch_ev;
  logic [NCH-1:0][CW-1:0] gcnt_q, gcnt_d;
`endif

  always_comb begin
    sync1_d = bus.raw_x;
    sync2_d = sync1_q;
  end

  // Pulses default low so they last exactly one cycle after a commit edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
`ifdef GLITCH_CNT_EN
    glitch_ev = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (sync2_q[i] != clean_q[i]) begin
            state_d[i] = ST_CHECK;
            cnt_d[i]   = CW'(1);
          end
        end
        ST_CHECK: begin
          if (sync2_q[i] == clean_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
`ifdef GLITCH_CNT_EN
            glitch_ev[i] = 1'b1;
`endif
          end else if (cnt_q[i] == DEB_LAST) begin
            clean_d[i] = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Startup counter is one bit wider so DEB_CYCLES+2 never wraps.
  always_comb begin
    start_d   = start_q;
    settled_d = settled_q;
    if (!settled_q) begin
      start_d = start_q + SW'(1);
      if (start_d == START_LAST) begin
        settled_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= {NCH{ST_IDLE}};
      cnt_q     <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      start_q   <= '0;
      settled_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      start_q   <= start_d;
      settled_q <= settled_d;
    end
  end

`ifdef GLITCH_CNT_EN
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (glitch_ev[i] && (gcnt_q[i] != {CW{1'b1}})) begin
        gcnt_d[i] = gcnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign bus.glitch_cnt = gcnt_q;
`else
  assign bus.glitch_cnt = '0;
`endif

  assign bus.x_clean = clean_q;
  assign bus.x_rise  = rise_q;
  assign bus.x_fall  = fall_q;
  assign bus.settled = settled_q;

endmodule

// File: tb/tb_robot_sensor_conditioner.sv
// tb/tb_robot_sensor_conditioner.sv - directed self-checking bench for robot_sensor_conditioner
// Expected glitch counts follow GLITCH_CNT_EN.
module tb_robot_sensor_conditioner;
  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int DEB = 4;
`ifdef GLITCH_CNT_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  robot_sensor_conditioner_if #(.NCH(NCH), .CW(CW)) bus();

  robot_sensor_conditioner #(.NCH(NCH), .DEB_CYCLES(DEB), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] clean;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       settled;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] raw, input logic [4:0] clean, input logic [4:0] rise,
                     input logic [4:0] fall, input logic settled);
    vec_t v;
    v.raw = raw; v.clean = clean; v.rise = rise; v.fall = fall; v.settled = settled;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] gexp(input int n);
    if (!GEN) return '0;
    return (n > 255) ? 8'hFF : CW'(n);
  endfunction

  function automatic logic [CW-1:0] gch(input int ch);
    return bus.glitch_cnt[ch*CW +: CW];
  endfunction

  initial begin
    int rise0;
    rst        = 1'b1;
    bus.raw_x  = '0;

    // Rows: raw driven before edge n, outputs checked after edge n (edge 1 = first after release)
    for (int i = 0; i < 5; i++) add(5'h00, 5'h00, 5'h00, 5'h00, 1'b0);
    add(5'h00, 5'h00, 5'h00, 5'h00, 1'b1);
    for (int i = 0; i < 6; i++) add(5'h1F, 5'h00, 5'h00, 5'h00, 1'b1);
    add(5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b1);
    add(5'h1F, 5'h1F, 5'h00, 5'h00, 1'b1);
    for (int i = 0; i < 6; i++) add(5'h00, 5'h1F, 5'h00, 5'h00, 1'b1);
    add(5'h00, 5'h00, 5'h00, 5'h1F, 1'b1);
    add(5'h00, 5'h00, 5'h00, 5'h00, 1'b1);
    for (int i = 0; i < 6; i++) add(5'h08, 5'h00, 5'h00, 5'h00, 1'b1);
    add(5'h08, 5'h08, 5'h08, 5'h00, 1'b1);
    add(5'h08, 5'h08, 5'h00, 5'h00, 1'b1);

    repeat (3) tick();
    chk("reset_clean", bus.x_clean, 0);
    chk("reset_rise", bus.x_rise, 0);
    chk("reset_fall", bus.x_fall, 0);
    chk("reset_settled", bus.settled, 0);
    chk("reset_glitch", bus.glitch_cnt, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      bus.raw_x = vecs[i].raw;
      tick();
      chk($sformatf("row%0d_clean", i + 1), bus.x_clean, vecs[i].clean);
      chk($sformatf("row%0d_rise", i + 1), bus.x_rise, vecs[i].rise);
      chk($sformatf("row%0d_fall", i + 1), bus.x_fall, vecs[i].fall);
      chk($sformatf("row%0d_settled", i + 1), bus.settled, vecs[i].settled);
      chk($sformatf("row%0d_glitch", i + 1), bus.glitch_cnt, 0);
    end

    // Single-cycle glitch on channel 0
    bus.raw_x = 5'h09;
    tick();
    bus.raw_x = 5'h08;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("glitch0_clean", bus.x_clean, 5'h08);
      chk("glitch0_rise", bus.x_rise, 0);
      chk("glitch0_fall", bus.x_fall, 0);
    end
    chk("glitch0_count", gch(0), gexp(1));

    // Channel 1: high 4 samples, low 1, then high; commit 6 edges after resume
    bus.raw_x = 5'h0A;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("resume_early_rise", bus.x_rise, 0);
    end
    bus.raw_x = 5'h08;
    tick();
    chk("resume_gap_rise", bus.x_rise, 0);
    bus.raw_x = 5'h0A;
    tick();
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk($sformatf("resume_e%0d_rise", j), bus.x_rise, (j == 6) ? 5'h02 : 5'h00);
      chk($sformatf("resume_e%0d_clean", j), bus.x_clean, (j >= 6) ? 5'h0A : 5'h08);
    end
    chk("resume_glitch1", gch(1), gexp(1));

    // Reset two edges into a channel 2 debounce
    bus.raw_x = 5'h0E;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_clean", bus.x_clean, 0);
    chk("midrst_rise", bus.x_rise, 0);
    chk("midrst_fall", bus.x_fall, 0);
    chk("midrst_settled", bus.settled, 0);
    chk("midrst_glitch", bus.glitch_cnt, 0);
    repeat (2) tick();
    bus.raw_x = 5'h06;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("rel_e%0d_clean", e), bus.x_clean, (e >= 7) ? 5'h06 : 5'h00);
      chk($sformatf("rel_e%0d_rise", e), bus.x_rise, (e == 7) ? 5'h06 : 5'h00);
      chk($sformatf("rel_e%0d_fall", e), bus.x_fall, 0);
      chk($sformatf("rel_e%0d_settled", e), bus.settled, (e >= 6) ? 1'b1 : 1'b0);
    end

    // Glitch counter saturation on channel 0
    rise0 = 0;
    for (int g = 1; g <= 300; g++) begin
      bus.raw_x = 5'h07;
      tick();
      if (bus.x_rise[0] || bus.x_fall[0]) rise0++;
      bus.raw_x = 5'h06;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (bus.x_rise[0] || bus.x_fall[0]) rise0++;
      end
      if (g == 255) chk("sat_at_255", gch(0), gexp(255));
    end
    chk("sat_pulses0", rise0, 0);
    chk("sat_count0", gch(0), gexp(300));
    chk("sat_count1", gch(1), gexp(0));
    chk("sat_clean", bus.x_clean, 5'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
